// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Package     : matmul_pkg
// Description : Shared types and helpers for the matmul core and its
//               result-streaming stage.
//               - streamer_state_t : IDLE / STREAM states of the Z streamer
//               - word_count()     : number of words in an N x N matrix
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } streamer_state_t;

    // Words in a square matrix of side n.
    function automatic int unsigned word_count(input int unsigned n);
        return n * n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/z_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : z_out_fifo
// Description : Two-entry synchronous FIFO carrying a data word plus a last
//               flag. The head entry is presented combinationally from the
//               storage registers, so it holds steady while not popped.
// Ports       : clock        - rising-edge clock
//               reset        - synchronous, active-low reset
//               i_push       - write i_push_data / i_push_last this edge
//               i_push_data  - word to store
//               i_push_last  - last flag to store
//               i_pop        - drop the head entry this edge
//               o_head_data  - head word
//               o_head_last  - head last flag
//               o_occ        - occupancy (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module z_out_fifo #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_push_last,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic                  o_head_last,
    output logic [1:0]            o_occ
);

    logic [DATA_WIDTH-1:0] r_data [2];
    logic [1:0]            r_last;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_occ;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_last    <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_occ     <= 2'd0;
        end else begin
            // On a full buffer with simultaneous pop the write lands in the
            // slot being vacated; the head was consumed before this edge.
            if (i_push) begin
                r_data[r_wr_ptr] <= i_push_data;
                r_last[r_wr_ptr] <= i_push_last;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // The upstream issue rule must never overfill the buffer.
    always_ff @(posedge clock) begin
        assert (!(reset && i_push && !i_pop && (r_occ == 2'd2)))
            else $error("z_out_fifo: push into full buffer");
    end

    assign o_head_data = r_data[r_rd_ptr];
    assign o_head_last = r_last[r_rd_ptr];
    assign o_occ       = r_occ;

endmodule
`default_nettype wire

// File: rtl/z_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : z_result_streamer
// Description : After the matmul core signals completion, reads the N x N
//               result from the Z BRAM (row-major, addr 0..N*N-1) and emits
//               it as a valid/ready stream with a last flag. A 2-entry output
//               buffer hides the 1-cycle BRAM read latency so that a
//               continuously-ready consumer receives one word per cycle.
// Ports       : clock     - rising-edge clock
//               reset     - synchronous, active-low reset
//               trigger   - run request (matmul done pulse)
//               z_rd_addr - Z BRAM read address (data returned next cycle)
//               z_dout    - Z BRAM read data
//               m_data    - stream data
//               m_valid   - stream valid
//               m_ready   - stream ready (consumer backpressure)
//               m_last    - high with the final word
//               busy      - high while streaming
//               done      - 1-cycle pulse after the last handshake
// Revision    : 1.0 - initial release
// ============================================================================
module z_result_streamer
    import matmul_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = 6,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int MATRIX_SIZE     = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       trigger,
    output logic [BRAM_ADDR_WIDTH-1:0] z_rd_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] z_dout,
    output logic [BRAM_DATA_WIDTH-1:0] m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_last,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned          c_words_int = word_count(MATRIX_SIZE);
    localparam logic [BRAM_ADDR_WIDTH:0] c_words = (BRAM_ADDR_WIDTH + 1)'(c_words_int);
    localparam logic [BRAM_ADDR_WIDTH:0] c_last_idx = c_words - 1'b1;

    generate
        if (c_words_int > (2 ** BRAM_ADDR_WIDTH)) begin : g_size_check
            $error("z_result_streamer: MATRIX_SIZE**2 exceeds Z BRAM depth");
        end
    endgenerate

    streamer_state_t              r_state;
    logic [BRAM_ADDR_WIDTH:0]     r_rd_cnt;   // reads issued this run
    logic [BRAM_ADDR_WIDTH:0]     r_wr_cnt;   // words written into buffer
    logic                         r_inflight; // read issued last cycle
    logic                         r_done;

    logic [1:0]                   w_occ;
    logic                         w_pop;
    logic                         w_issue;
    logic [2:0]                   w_fill;
    logic [2:0]                   w_limit;

    assign w_pop   = m_valid & m_ready;

    // A slot is free for a new read if occupancy plus the read already in
    // flight stays below two once this cycle's pop is accounted for.
    assign w_fill  = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_limit = 3'd2 + {2'b00, w_pop};
    assign w_issue = (r_state == STREAM) && (r_rd_cnt < c_words) && (w_fill < w_limit);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (r_inflight) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (trigger) begin
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    // Counters return to zero so the read address idles at 0
                    // and the next run starts from the first word.
                    if (w_pop && m_last) begin
                        r_state  <= IDLE;
                        r_done   <= 1'b1;
                        r_rd_cnt <= '0;
                        r_wr_cnt <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    z_out_fifo #(
        .DATA_WIDTH (BRAM_DATA_WIDTH)
    ) u_out_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (r_inflight),
        .i_push_data (z_dout),
        .i_push_last (r_wr_cnt == c_last_idx),
        .i_pop       (w_pop),
        .o_head_data (m_data),
        .o_head_last (m_last),
        .o_occ       (w_occ)
    );

    assign z_rd_addr = r_rd_cnt[BRAM_ADDR_WIDTH-1:0];
    assign m_valid   = (w_occ != 2'd0);
    assign busy      = (r_state == STREAM);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_z_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_z_result_streamer
// Description : Directed self-checking bench for z_result_streamer. One
//               instance uses the default 8x8 configuration, a second a 4x4
//               configuration. Each Z BRAM model returns its read address
//               (plus an offset on the 4x4 instance) one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_z_result_streamer;

    logic        clock;
    logic        reset;

    // 8x8 instance
    logic        trigger;
    logic [5:0]  z_rd_addr;
    logic [31:0] z_dout;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic        done;

    // 4x4 instance
    logic        trigger_b;
    logic [3:0]  z_rd_addr_b;
    logic [31:0] z_dout_b;
    logic [31:0] m_data_b;
    logic        m_valid_b;
    logic        m_ready_b;
    logic        m_last_b;
    logic        busy_b;
    logic        done_b;

    int n_pass;
    int n_total;

    int cyc;
    int hs_n;
    int done_n;
    int first_valid;
    int last_cyc;
    int done_cyc;
    logic        prev_stall;
    logic [31:0] prev_data;

    z_result_streamer #(
        .BRAM_ADDR_WIDTH (6),
        .BRAM_DATA_WIDTH (32),
        .MATRIX_SIZE     (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .trigger   (trigger),
        .z_rd_addr (z_rd_addr),
        .z_dout    (z_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    z_result_streamer #(
        .BRAM_ADDR_WIDTH (4),
        .BRAM_DATA_WIDTH (32),
        .MATRIX_SIZE     (4)
    ) dut_b (
        .clock     (clock),
        .reset     (reset),
        .trigger   (trigger_b),
        .z_rd_addr (z_rd_addr_b),
        .z_dout    (z_dout_b),
        .m_data    (m_data_b),
        .m_valid   (m_valid_b),
        .m_ready   (m_ready_b),
        .m_last    (m_last_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Z BRAM models: word at address a holds a (8x8) or a + 0x100 (4x4).
    always @(posedge clock) begin
        z_dout   <= 32'(z_rd_addr);
        z_dout_b <= 32'(z_rd_addr_b) + 32'h100;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the 8x8 instance: check the handshake about to happen,
    // then advance past the edge and record what the edge produced.
    task automatic tick_a();
        #3;
        if (prev_stall) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", m_data, prev_data);
        end
        if (m_valid && m_ready) begin
            chk("word_data", m_data, 32'(hs_n));
            chk("word_last", 32'(m_last), 32'(hs_n == 63));
            if (m_last) last_cyc = cyc;
            hs_n++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        @(posedge clock);
        #1;
        cyc++;
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (busy && (int'(z_rd_addr) >= hs_n)) begin
            chk("outstanding", 32'((int'(z_rd_addr) - hs_n) <= 2), 32'd1);
        end
    endtask

    // mode 0: ready high; 1: ready toggles; 2: ready low 20 cycles;
    // 3: retrigger during word 10; 4: stop after word 30 (for reset test)
    task automatic run_a(input int mode, input int budget);
        logic trig_sent;
        hs_n = 0; done_n = 0; first_valid = -1; last_cyc = -1; done_cyc = -1;
        prev_stall = 1'b0; prev_data = '0; cyc = -1; trig_sent = 1'b0;
        trigger = 1'b1;
        m_ready = (mode == 2) ? 1'b0 : 1'b1;
        tick_a();
        trigger = 1'b0;
        while (done_n == 0 && cyc < budget && !(mode == 4 && hs_n >= 31)) begin
            case (mode)
                1:       m_ready = ((cyc % 2) == 1);
                2:       m_ready = (cyc >= 20);
                default: m_ready = 1'b1;
            endcase
            if (mode == 3 && hs_n == 10 && !trig_sent) begin
                trigger   = 1'b1;
                trig_sent = 1'b1;
            end else begin
                trigger = 1'b0;
            end
            tick_a();
            if (cyc == 1) chk("busy_start", 32'(busy), 32'd1);
            if (mode == 2 && cyc == 19) begin
                chk("stall_rd_addr", 32'(z_rd_addr), 32'd2);
                chk("stall_valid0", 32'(m_valid), 32'd1);
                chk("stall_word0", m_data, 32'd0);
            end
        end
        trigger = 1'b0;
        if (mode != 4) begin
            chk("done_seen", 32'(done_n), 32'd1);
            chk("word_count", 32'(hs_n), 32'd64);
            chk("busy_end", 32'(busy), 32'd0);
            if (mode == 0) begin
                chk("first_valid_cyc", 32'(first_valid), 32'd2);
                chk("last_cyc", 32'(last_cyc), 32'd65);
                chk("done_cyc", 32'(done_cyc), 32'd66);
            end
            m_ready = 1'b1;
            repeat (3) tick_a();
            chk("no_extra_words", 32'(hs_n), 32'd64);
            chk("single_done", 32'(done_n), 32'd1);
            chk("idle_valid", 32'(m_valid), 32'd0);
        end
    endtask

    initial begin
        int hs_b;
        int first_b;
        int last_b;
        int done_b_cyc;

        n_pass = 0; n_total = 0;
        reset = 1'b0; trigger = 1'b0; m_ready = 1'b0;
        trigger_b = 1'b0; m_ready_b = 1'b1;
        cyc = 0; hs_n = 0; done_n = 0; prev_stall = 1'b0; prev_data = '0;
        first_valid = -1; last_cyc = -1; done_cyc = -1;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_rd_addr", 32'(z_rd_addr), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_data", m_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid_b", 32'(m_valid_b), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        run_a(0, 200);   // full throughput
        run_a(1, 300);   // alternating backpressure
        run_a(2, 200);   // long initial stall
        run_a(3, 200);   // trigger while busy is ignored
        run_a(0, 200);   // fresh run after done

        // Reset in the middle of a run
        run_a(4, 200);
        reset = 1'b0;
        tick_a();
        chk("midrst_valid", 32'(m_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rd_addr", 32'(z_rd_addr), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        reset = 1'b1;
        tick_a();
        run_a(0, 200);

        // 4x4 configuration
        hs_b = 0; first_b = -1; last_b = -1; done_b_cyc = -1; cyc = -1;
        trigger_b = 1'b1;
        while (done_b_cyc < 0 && cyc < 60) begin
            #3;
            if (m_valid_b && m_ready_b) begin
                chk("b_word_data", m_data_b, 32'(hs_b) + 32'h100);
                chk("b_word_last", 32'(m_last_b), 32'(hs_b == 15));
                if (m_last_b) last_b = cyc;
                hs_b++;
            end
            @(posedge clock);
            #1;
            cyc++;
            trigger_b = 1'b0;
            if (m_valid_b && first_b < 0) first_b = cyc;
            if (done_b) done_b_cyc = cyc;
        end
        chk("b_word_count", 32'(hs_b), 32'd16);
        chk("b_first_valid", 32'(first_b), 32'd2);
        chk("b_last_cyc", 32'(last_b), 32'd17);
        chk("b_done_cyc", 32'(done_b_cyc), 32'd18);
        chk("b_busy_end", 32'(busy_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
